// File: rtl/s32x_fb_mem_ctrl.sv
// rtl/s32x_fb_mem_ctrl.sv - 32X VDP framebuffer port to shared word memory bridge
// Turns level-held VDP strobes into single memory requests, posts writes, prioritises reads.
module s32x_fb_mem_ctrl #(
    parameter int AW       = 16,
    parameter int WQ_DEPTH = 2,
    parameter int BANK     = 0
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [AW-1:0] FB_A,
    input  logic [15:0]   FB_D,
    input  logic [1:0]    FB_WE,
    input  logic          FB_RD,
    output logic [15:0]   FB_Q,
    output logic [AW:0]   MEM_A,
    output logic [15:0]   MEM_D,
    output logic [1:0]    MEM_BE,
    output logic          MEM_WR,
    output logic          MEM_RD,
    input  logic [15:0]   MEM_Q,
    input  logic          MEM_RDY,
    output logic          BUSY,
    output logic          WQ_OVF
);
    localparam int   PW       = $clog2(WQ_DEPTH);
    localparam logic BANK_BIT = 1'(BANK);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
    state_t state;

    logic [AW-1:0] q_a  [WQ_DEPTH];
    logic [1:0]    q_be [WQ_DEPTH];
    logic [15:0]   q_d  [WQ_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, last_ptr;
    logic [PW:0]   count;

    logic [1:0]    prev_we;
    logic [AW-1:0] prev_a;
    logic          rd_d;
    logic          rp_v;
    logic [AW-1:0] rp_a;

    logic wr_new, rd_new, raw_hit, go_read, pop, can_merge, q_full, push, drop;
    logic [15:0] merged_d;

    always_comb begin
        wr_new   = (FB_WE != 2'b00) &&
                   ((prev_we == 2'b00) || (FB_A != prev_a) || (FB_WE != prev_we));
        rd_new   = FB_RD & ~rd_d;
        last_ptr = wr_ptr - 1'b1;
        raw_hit  = 1'b0;
        for (int i = 0; i < WQ_DEPTH; i++) begin
            if (((PW+1)'(i) < count) && (q_a[rd_ptr + PW'(i)] == rp_a))
                raw_hit = 1'b1;
        end
        go_read   = (state == IDLE) && rp_v && !raw_hit;
        pop       = (state == IDLE) && !go_read && (count != '0);
        // The head being popped this cycle is already committed to memory and cannot absorb bytes.
        can_merge = (count != '0) && (q_a[last_ptr] == FB_A) &&
                    !(pop && (count == (PW+1)'(1)));
        q_full    = (count == (PW+1)'(WQ_DEPTH));
        push      = wr_new && !can_merge && (!q_full || pop);
        drop      = wr_new && !can_merge && q_full && !pop;
        merged_d  = {FB_WE[1] ? FB_D[15:8] : q_d[last_ptr][15:8],
                     FB_WE[0] ? FB_D[7:0]  : q_d[last_ptr][7:0]};
    end

    assign BUSY = (state != IDLE) || (count != '0) || rp_v;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            prev_we <= '0;
            prev_a  <= '0;
            rd_d    <= 1'b0;
            rp_v    <= 1'b0;
            rp_a    <= '0;
            FB_Q    <= '0;
            MEM_A   <= '0;
            MEM_D   <= '0;
            MEM_BE  <= '0;
            MEM_WR  <= 1'b0;
            MEM_RD  <= 1'b0;
            WQ_OVF  <= 1'b0;
        end else begin
            prev_we <= FB_WE;
            prev_a  <= FB_A;
            rd_d    <= FB_RD;

            if (push) begin
                q_a[wr_ptr]  <= FB_A;
                q_be[wr_ptr] <= FB_WE;
                q_d[wr_ptr]  <= FB_D;
                wr_ptr       <= wr_ptr + 1'b1;
            end
            if (wr_new && can_merge) begin
                q_be[last_ptr] <= q_be[last_ptr] | FB_WE;
                q_d[last_ptr]  <= merged_d;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
            if (drop)
                WQ_OVF <= 1'b1;

            // RP is consumed at issue so a read arriving during flight stays pending.
            if (rd_new) begin
                rp_v <= 1'b1;
                rp_a <= FB_A;
            end else if (go_read) begin
                rp_v <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (go_read) begin
                        state  <= READ;
                        MEM_RD <= 1'b1;
                        MEM_A  <= {BANK_BIT, rp_a};
                    end else if (pop) begin
                        state  <= WRITE;
                        MEM_WR <= 1'b1;
                        MEM_A  <= {BANK_BIT, q_a[rd_ptr]};
                        MEM_D  <= q_d[rd_ptr];
                        MEM_BE <= q_be[rd_ptr];
                    end
                end
                READ: begin
                    if (MEM_RDY) begin
                        state  <= IDLE;
                        MEM_RD <= 1'b0;
                        FB_Q   <= MEM_Q;
                    end
                end
                WRITE: begin
                    if (MEM_RDY) begin
                        state  <= IDLE;
                        MEM_WR <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_s32x_fb_mem_ctrl.sv
// tb/tb_s32x_fb_mem_ctrl.sv - directed bench for s32x_fb_mem_ctrl
module tb_s32x_fb_mem_ctrl;
    logic        CLK;
    logic        RST;
    logic [15:0] FB_A;
    logic [15:0] FB_D;
    logic [1:0]  FB_WE;
    logic        FB_RD;
    logic [15:0] FB_Q;
    logic [16:0] MEM_A;
    logic [15:0] MEM_D;
    logic [1:0]  MEM_BE;
    logic        MEM_WR;
    logic        MEM_RD;
    logic [15:0] MEM_Q;
    logic        MEM_RDY;
    logic        BUSY;
    logic        WQ_OVF;

    int vectors = 0;
    int errors  = 0;
    int wr_pulses = 0;
    int lat = 3;
    bit rdy_en = 0;
    bit both_seen = 0;
    bit unstable = 0;
    logic [35:0] log_q [$];
    logic [15:0] mem [logic [16:0]];

    s32x_fb_mem_ctrl #(.AW(16), .WQ_DEPTH(2), .BANK(1)) dut (
        .CLK(CLK), .RST(RST), .FB_A(FB_A), .FB_D(FB_D), .FB_WE(FB_WE), .FB_RD(FB_RD),
        .FB_Q(FB_Q), .MEM_A(MEM_A), .MEM_D(MEM_D), .MEM_BE(MEM_BE), .MEM_WR(MEM_WR),
        .MEM_RD(MEM_RD), .MEM_Q(MEM_Q), .MEM_RDY(MEM_RDY), .BUSY(BUSY), .WQ_OVF(WQ_OVF)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Memory responder: completes a request after lat cycles, logs {wr, A, D, BE}.
    initial begin : responder
        int wait_cnt;
        logic [15:0] old;
        wait_cnt = 0;
        forever begin
            @(negedge CLK);
            if (rdy_en) begin
                if (MEM_RDY) begin
                    MEM_RDY = 1'b0;
                    wait_cnt = 0;
                end else if (MEM_WR || MEM_RD) begin
                    wait_cnt++;
                    if (wait_cnt >= lat) begin
                        MEM_RDY = 1'b1;
                        old = mem.exists(MEM_A) ? mem[MEM_A] : (16'hA5A5 ^ MEM_A[15:0]);
                        if (MEM_WR) begin
                            mem[MEM_A] = {MEM_BE[1] ? MEM_D[15:8] : old[15:8],
                                          MEM_BE[0] ? MEM_D[7:0]  : old[7:0]};
                            log_q.push_back({1'b1, MEM_A, MEM_D, MEM_BE});
                        end else begin
                            MEM_Q = old;
                            log_q.push_back({1'b0, MEM_A, 16'h0000, 2'b00});
                        end
                    end
                end else begin
                    wait_cnt = 0;
                end
            end
        end
    end

    initial begin : monitor
        logic [36:0] snap_prev;
        logic req_prev, wr_prev;
        req_prev = 1'b0;
        wr_prev  = 1'b0;
        snap_prev = '0;
        forever begin
            @(posedge CLK);
            #1;
            if (MEM_WR && MEM_RD) both_seen = 1;
            if (req_prev && !MEM_RDY && !RST && ({MEM_A, MEM_D, MEM_BE, MEM_WR, MEM_RD} !== snap_prev))
                unstable = 1;
            if (MEM_WR && !wr_prev) wr_pulses++;
            snap_prev = {MEM_A, MEM_D, MEM_BE, MEM_WR, MEM_RD};
            req_prev  = MEM_WR || MEM_RD;
            wr_prev   = MEM_WR;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic fb_write(input logic [15:0] a, input logic [15:0] d, input logic [1:0] we, input int hold);
        FB_A = a; FB_D = d; FB_WE = we;
        tick(hold);
        FB_WE = 2'b00;
        tick(1);
    endtask

    task automatic fb_read(input logic [15:0] a);
        FB_A = a; FB_RD = 1'b1;
        tick(1);
        FB_RD = 1'b0;
        tick(1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (BUSY !== 1'b0 && n < 300) begin
            tick(1);
            n++;
        end
        tick(1);
        vectors++;
        if (BUSY !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: BUSY got %b expected 0 after 300 cycles", name, BUSY);
        end
    endtask

    task automatic test_reset;
        RST = 1'b1; FB_A = '0; FB_D = '0; FB_WE = '0; FB_RD = 1'b0;
        MEM_Q = '0; MEM_RDY = 1'b0;
        tick(2);
        RST = 1'b0;
        vectors++;
        if ({MEM_WR, MEM_RD, BUSY, WQ_OVF} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b expected 0000", {MEM_WR, MEM_RD, BUSY, WQ_OVF});
        end
        vectors++;
        if (FB_Q !== 16'h0000) begin
            errors++; $display("FAIL reset_fbq: got %h expected 0000", FB_Q);
        end
        vectors++;
        if ({MEM_A, MEM_D, MEM_BE} !== 35'h0) begin
            errors++; $display("FAIL reset_mem_bus: got %h expected 0", {MEM_A, MEM_D, MEM_BE});
        end
        tick(3);
        vectors++;
        if ({MEM_WR, MEM_RD, BUSY, WQ_OVF} !== 4'b0000) begin
            errors++; $display("FAIL reset_quiet: got %b expected 0000", {MEM_WR, MEM_RD, BUSY, WQ_OVF});
        end
    endtask

    task automatic test_held_write;
        int p0;
        log_q.delete(); p0 = wr_pulses; rdy_en = 1; lat = 3;
        fb_write(16'h1234, 16'hABCD, 2'b11, 6);
        wait_idle("held");
        vectors++;
        if (log_q.size() !== 1) begin
            errors++; $display("FAIL held_count: got %0d expected 1", log_q.size());
        end
        vectors++;
        if (log_q[0] !== {1'b1, 17'h11234, 16'hABCD, 2'b11}) begin
            errors++; $display("FAIL held_txn: got %h expected %h", log_q[0], {1'b1, 17'h11234, 16'hABCD, 2'b11});
        end
        vectors++;
        if (wr_pulses - p0 !== 1) begin
            errors++; $display("FAIL held_pulses: got %0d expected 1", wr_pulses - p0);
        end
    endtask

    task automatic test_merge;
        rdy_en = 0; MEM_RDY = 1'b0; log_q.delete();
        fb_write(16'h0050, 16'h0F0F, 2'b11, 1);
        fb_write(16'h0010, 16'h12FF, 2'b10, 1);
        fb_write(16'h0010, 16'hEE34, 2'b01, 1);
        rdy_en = 1;
        wait_idle("merge");
        vectors++;
        if (log_q.size() !== 2) begin
            errors++; $display("FAIL merge_count: got %0d expected 2", log_q.size());
        end
        vectors++;
        if (log_q[1] !== {1'b1, 17'h10010, 16'h1234, 2'b11}) begin
            errors++; $display("FAIL merge_txn: got %h expected %h", log_q[1], {1'b1, 17'h10010, 16'h1234, 2'b11});
        end
    endtask

    task automatic test_read_priority;
        rdy_en = 0; MEM_RDY = 1'b0; log_q.delete();
        fb_write(16'h0060, 16'h6666, 2'b11, 1);
        fb_write(16'h0020, 16'h2222, 2'b11, 1);
        fb_read(16'h0030);
        rdy_en = 1;
        wait_idle("rdpri");
        vectors++;
        if (log_q.size() !== 3) begin
            errors++; $display("FAIL rdpri_count: got %0d expected 3", log_q.size());
        end
        vectors++;
        if (log_q[1] !== {1'b0, 17'h10030, 16'h0000, 2'b00}) begin
            errors++; $display("FAIL rdpri_read_first: got %h expected %h", log_q[1], {1'b0, 17'h10030, 18'h0});
        end
        vectors++;
        if (log_q[2] !== {1'b1, 17'h10020, 16'h2222, 2'b11}) begin
            errors++; $display("FAIL rdpri_write_second: got %h expected %h", log_q[2], {1'b1, 17'h10020, 16'h2222, 2'b11});
        end
        vectors++;
        if (FB_Q !== 16'hA595) begin
            errors++; $display("FAIL rdpri_fbq: got %h expected A595", FB_Q);
        end
        fb_write(16'h0070, 16'h7777, 2'b11, 1);
        wait_idle("rdhold");
        vectors++;
        if (FB_Q !== 16'hA595) begin
            errors++; $display("FAIL rdpri_fbq_hold: got %h expected A595", FB_Q);
        end
    endtask

    task automatic test_raw;
        rdy_en = 0; MEM_RDY = 1'b0; log_q.delete();
        fb_write(16'h0080, 16'h8888, 2'b11, 1);
        fb_write(16'h0040, 16'h5555, 2'b11, 1);
        fb_read(16'h0040);
        rdy_en = 1;
        wait_idle("raw");
        vectors++;
        if (log_q[1] !== {1'b1, 17'h10040, 16'h5555, 2'b11}) begin
            errors++; $display("FAIL raw_write_first: got %h expected %h", log_q[1], {1'b1, 17'h10040, 16'h5555, 2'b11});
        end
        vectors++;
        if (log_q[2] !== {1'b0, 17'h10040, 16'h0000, 2'b00}) begin
            errors++; $display("FAIL raw_read_second: got %h expected %h", log_q[2], {1'b0, 17'h10040, 18'h0});
        end
        vectors++;
        if (FB_Q !== 16'h5555) begin
            errors++; $display("FAIL raw_fbq: got %h expected 5555", FB_Q);
        end
    endtask

    task automatic test_overflow;
        int p0;
        rdy_en = 0; MEM_RDY = 1'b0; log_q.delete(); p0 = wr_pulses;
        fb_read(16'h00A0);
        fb_write(16'h0090, 16'h9090, 2'b11, 1);
        fb_write(16'h0091, 16'h9191, 2'b11, 1);
        vectors++;
        if (WQ_OVF !== 1'b0) begin
            errors++; $display("FAIL ovf_not_yet: got %b expected 0", WQ_OVF);
        end
        fb_write(16'h0092, 16'h9292, 2'b11, 1);
        vectors++;
        if (WQ_OVF !== 1'b1) begin
            errors++; $display("FAIL ovf_set: got %b expected 1", WQ_OVF);
        end
        rdy_en = 1;
        wait_idle("ovf");
        vectors++;
        if (wr_pulses - p0 !== 2) begin
            errors++; $display("FAIL ovf_pulses: got %0d expected 2", wr_pulses - p0);
        end
        vectors++;
        if (log_q.size() !== 3 || log_q[2] !== {1'b1, 17'h10091, 16'h9191, 2'b11}) begin
            errors++; $display("FAIL ovf_log: got %0d entries last %h expected 3 last %h",
                               log_q.size(), log_q[2], {1'b1, 17'h10091, 16'h9191, 2'b11});
        end
        vectors++;
        if ({WQ_OVF, FB_Q} !== {1'b1, 16'hA505}) begin
            errors++; $display("FAIL ovf_sticky_fbq: got %h expected 1A505", {WQ_OVF, FB_Q});
        end
    endtask

    task automatic test_reset_mid;
        rdy_en = 0; MEM_RDY = 1'b0;
        fb_write(16'h00B0, 16'hB0B0, 2'b11, 1);
        vectors++;
        if (MEM_WR !== 1'b1) begin
            errors++; $display("FAIL rstmid_inflight: MEM_WR got %b expected 1", MEM_WR);
        end
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        vectors++;
        if ({MEM_WR, MEM_RD, BUSY, WQ_OVF} !== 4'b0000) begin
            errors++; $display("FAIL rstmid_drop: got %b expected 0000", {MEM_WR, MEM_RD, BUSY, WQ_OVF});
        end
        MEM_Q = 16'hDEAD; MEM_RDY = 1'b1;
        tick(1);
        MEM_RDY = 1'b0;
        tick(2);
        vectors++;
        if ({FB_Q, MEM_WR, MEM_RD, BUSY} !== 19'h0) begin
            errors++; $display("FAIL rstmid_stray_rdy: got %h expected 0", {FB_Q, MEM_WR, MEM_RD, BUSY});
        end
    endtask

    initial begin
        test_reset();
        test_held_write();
        test_merge();
        test_read_priority();
        test_raw();
        test_overflow();
        test_reset_mid();
        vectors++;
        if (both_seen !== 1'b0) begin
            errors++; $display("FAIL rd_wr_exclusive: got %b expected 0", both_seen);
        end
        vectors++;
        if (unstable !== 1'b0) begin
            errors++; $display("FAIL mem_stable: got %b expected 0", unstable);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
